jt900h_rfile_banked: RTL and testbench

Parametrised banked CPU register file for the JT900H core: BANKS general banks of 16 bytes (XWA, XBC, XDE, XHL) plus a shared 16-byte pointer file (XIX, XIY, XIZ, XSP). Adds behaviour the previous register file lacks:
- an RFP save stack for interrupt entry/exit;
- bytewise write/step merging;
- a BC zero flag.
Sits between the decoder/ALU/memory datapath and the status dump logic.

---
 rtl/jt900h_pkg.sv | 38 +++
 rtl/jt900h_rfile_banked_if.sv | 36 +++
 rtl/jt900h_rfile_banked_rfp_stack.sv | 61 ++++++
 rtl/jt900h_rfile_banked.sv | 149 ++++++++++++++
 tb/tb_jt900h_rfile_banked.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/jt900h_pkg.sv
// Shared constants for the JT900H banked register file: register codes,
// access sizes and the dump address map.
package jt900h_pkg;

    localparam logic [3:0] CURBANK  = 4'hE;
    localparam logic [3:0] PREVBANK = 4'hD;
    localparam logic [3:0] PTRFILE  = 4'hF;

    typedef enum logic [1:0] { SZ_BYTE, SZ_WORD, SZ_LONG, SZ_RSVD } size_e;

    // bit positions inside the we vector
    localparam int WE_BYTE = 0;
    localparam int WE_WORD = 1;
    localparam int WE_LONG = 2;

    // byte offsets inside a 16-byte file
    localparam int BC_LO  = 4;
    localparam int XSP_LO = 12;

    localparam logic [3:0] DMP_PTR   = 4'hF;
    localparam logic [7:0] DMP_RFP   = 8'hE0;
    localparam logic [7:0] DMP_FLAGS = 8'hE1;

    function automatic size_e we_size(logic [2:0] we);
        if (we[WE_LONG]) return SZ_LONG;
        if (we[WE_WORD]) return SZ_WORD;
        return SZ_BYTE;
    endfunction

    function automatic logic [31:0] step_amt(logic [1:0] sz);
        case (size_e'(sz))
            SZ_WORD: return 32'd2;
            SZ_LONG: return 32'd4;
            default: return 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/jt900h_rfile_banked_if.sv
// Datapath-side bus of the banked register file (everything except clk/rst).
interface jt900h_rfile_banked_if #(parameter int BANKS = 4);
    localparam int RW = $clog2(BANKS);

    logic          cen;
    logic [RW-1:0] rfp;
    logic          rfp_we, rfp_inc, rfp_dec, rfp_push, rfp_pop;
    logic [RW-1:0] rfp_din;
    logic          rstk_full, rstk_err;
    logic [7:0]    rsel_a, rsel_b;
    logic [31:0]   rd_a, rd_b;
    logic          step_inc, step_dec;
    logic [1:0]    step_sz;
    logic [2:0]    we;
    logic [31:0]   wdata;
    logic          dec_bc, bc_zero, bc_unity;
    logic [15:0]   sp_inc, sp_dec;
    logic [31:0]   xsp, acc;
    logic [7:0]    dmp_addr, dmp_din;

    modport master (
        output cen, rfp_we, rfp_din, rfp_inc, rfp_dec, rfp_push, rfp_pop,
               rsel_a, rsel_b, step_inc, step_dec, step_sz, we, wdata,
               dec_bc, sp_inc, sp_dec, dmp_addr,
        input  rfp, rstk_full, rstk_err, rd_a, rd_b, bc_zero, bc_unity,
               xsp, acc, dmp_din
    );

    modport slave (
        input  cen, rfp_we, rfp_din, rfp_inc, rfp_dec, rfp_push, rfp_pop,
               rsel_a, rsel_b, step_inc, step_dec, step_sz, we, wdata,
               dec_bc, sp_inc, sp_dec, dmp_addr,
        output rfp, rstk_full, rstk_err, rd_a, rd_b, bc_zero, bc_unity,
               xsp, acc, dmp_din
    );
endinterface

// File: rtl/jt900h_rfile_banked_rfp_stack.sv
// Register file pointer with its interrupt save stack; a push onto a full
// stack drops the oldest entry.
module jt900h_rfp_stack #(
    parameter  int BANKS = 4,
    parameter  int DEPTH = 4,
    localparam int RW    = $clog2(BANKS),
    localparam int CW    = $clog2(DEPTH + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          push,
    input  logic          pop,
    input  logic          we,
    input  logic          inc,
    input  logic          dec,
    input  logic [RW-1:0] din,
    output logic [RW-1:0] rfp,
    output logic [RW-1:0] rfp_nxt,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          err
);
    logic [DEPTH-1:0][RW-1:0] stk;   // stk[0] is the top

    assign full = cnt == CW'(DEPTH);

    always_comb begin
        rfp_nxt = rfp;
        if (push)                 rfp_nxt = din;
        else if (pop) begin
            if (cnt != '0)        rfp_nxt = stk[0];
        end
        else if (we)              rfp_nxt = din;
        else if (inc && !dec)     rfp_nxt = rfp + RW'(1);
        else if (dec && !inc)     rfp_nxt = rfp - RW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rfp <= '0;
            stk <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else if (cen) begin
            rfp <= rfp_nxt;
            if (push) begin
                for (int i = DEPTH-1; i > 0; i--) stk[i] <= stk[i-1];
                stk[0] <= rfp;
                if (full) err <= 1'b1;
                else      cnt <= cnt + CW'(1);
            end else if (pop) begin
                if (cnt == '0) err <= 1'b1;
                else begin
                    for (int i = 0; i < DEPTH-1; i++) stk[i] <= stk[i+1];
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/jt900h_rfile_banked.sv
// JT900H banked register file: BANKS general banks, shared pointer file, RFP
// save stack, step/write merging and BC flags. Dump port: JT900H_RFILE_DUMP_EN.
module jt900h_rfile_banked
    import jt900h_pkg::*;
#(
    parameter int          BANKS      = 4,
    parameter int          RSTK_DEPTH = 4,
    parameter logic [31:0] SP_RST     = 32'h0000_0000
)(
    input logic               clk,
    input logic               rst,
    jt900h_rfile_banked_if.slave bus
);
    localparam int RW = $clog2(BANKS);
    localparam int CW = $clog2(RSTK_DEPTH + 1);

    typedef struct packed {
        logic          hit;
        logic          ptr;
        logic [RW-1:0] bank;
    } rsel_t;

    function automatic rsel_t resolve(logic [3:0] code, logic [RW-1:0] cur);
        rsel_t r;
        r = '0;
        if (code == PTRFILE)              begin r.hit = 1'b1; r.ptr  = 1'b1;           end
        else if (code == CURBANK)         begin r.hit = 1'b1; r.bank = cur;            end
        else if (code == PREVBANK)        begin r.hit = 1'b1; r.bank = cur - RW'(1);   end
        else if (int'(code) < BANKS)      begin r.hit = 1'b1; r.bank = code[RW-1:0];   end
        return r;
    endfunction

    logic [BANKS-1:0][15:0][7:0] bank_q, bank_d;
    logic [15:0][7:0]            ptr_q, ptr_d;
    logic [RW-1:0]               rfp, rfp_nxt;
    logic [CW-1:0]               rstk_cnt;
    rsel_t                       ra, rb;
    logic [3:0]                  la, lb, wa;
    logic [2:0]                  nb;
    logic [31:0]                 long_a, long_b, step, stepped;
    logic                        step_dn, bc_zero_q, bc_unity_q;
    logic [15:0]                 bc_nxt;

    jt900h_rfp_stack #(.BANKS(BANKS), .DEPTH(RSTK_DEPTH)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .cen     (bus.cen),
        .push    (bus.rfp_push),
        .pop     (bus.rfp_pop),
        .we      (bus.rfp_we),
        .inc     (bus.rfp_inc),
        .dec     (bus.rfp_dec),
        .din     (bus.rfp_din),
        .rfp     (rfp),
        .rfp_nxt (rfp_nxt),
        .cnt     (rstk_cnt),
        .full    (bus.rstk_full),
        .err     (bus.rstk_err)
    );

    always_comb begin
        ra      = resolve(bus.rsel_a[7:4], rfp);
        rb      = resolve(bus.rsel_b[7:4], rfp);
        la      = {bus.rsel_a[3:2], 2'b00};
        lb      = {bus.rsel_b[3:2], 2'b00};
        step    = step_amt(bus.step_sz);
        step_dn = bus.step_dec & ~bus.step_inc;
        long_a  = '0;
        long_b  = '0;
        if (ra.hit) long_a = ra.ptr ? ptr_q[la +: 4] : bank_q[ra.bank][la +: 4];
        if (rb.hit) long_b = rb.ptr ? ptr_q[lb +: 4] : bank_q[rb.bank][lb +: 4];
    end

    assign bus.rd_a = long_a >> {bus.rsel_a[1:0], 3'b000};
    assign bus.rd_b = (long_b >> {bus.rsel_b[1:0], 3'b000}) - ((rb.hit & step_dn) ? step : 32'd0);

    // Later sources override earlier ones: arithmetic, then step, then write.
    always_comb begin
        bank_d  = bank_q;
        ptr_d   = ptr_q;
        ptr_d[XSP_LO +: 4] = ptr_q[XSP_LO +: 4] + {16'd0, bus.sp_inc} - {16'd0, bus.sp_dec};
        if (bus.dec_bc) bank_d[rfp][BC_LO +: 2] = bank_q[rfp][BC_LO +: 2] - 16'd1;

        stepped = bus.step_inc ? long_a + step : long_a - step;
        if (ra.hit && (bus.step_inc ^ bus.step_dec)) begin
            if (ra.ptr) ptr_d[la +: 4] = stepped;
            else        bank_d[ra.bank][la +: 4] = stepped;
        end

        case (we_size(bus.we))
            SZ_LONG: begin wa = lb;                        nb = 3'd4; end
            SZ_WORD: begin wa = {bus.rsel_b[3:1], 1'b0};   nb = 3'd2; end
            default: begin wa = bus.rsel_b[3:0];           nb = 3'd1; end
        endcase
        if (rb.hit && |bus.we) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < nb) begin
                    if (rb.ptr) ptr_d[wa + 4'(i)] = bus.wdata[8*i +: 8];
                    else        bank_d[rb.bank][wa + 4'(i)] = bus.wdata[8*i +: 8];
                end
            end
        end

        bc_nxt = bank_d[rfp_nxt][BC_LO +: 2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q     <= '0;
            ptr_q      <= {SP_RST, 96'd0};
            bc_zero_q  <= 1'b1;
            bc_unity_q <= 1'b0;
        end else if (bus.cen) begin
            bank_q     <= bank_d;
            ptr_q      <= ptr_d;
            bc_zero_q  <= bc_nxt == 16'd0;
            bc_unity_q <= bc_nxt == 16'd1;
        end
    end

    assign bus.rfp      = rfp;
    assign bus.xsp      = ptr_q[XSP_LO +: 4];
    assign bus.acc      = bank_q[rfp][0 +: 4];
    assign bus.bc_zero  = bc_zero_q;
    assign bus.bc_unity = bc_unity_q;

`ifdef JT900H_RFILE_DUMP_EN
    logic [7:0] dmp_nxt, dmp_q;

    always_comb begin
        dmp_nxt = 8'd0;
        if (bus.dmp_addr[7:4] == DMP_PTR)            dmp_nxt = ptr_q[bus.dmp_addr[3:0]];
        else if (bus.dmp_addr == DMP_RFP)            dmp_nxt = {4'(rstk_cnt), 4'(rfp)};
        else if (bus.dmp_addr == DMP_FLAGS)          dmp_nxt = {6'd0, bc_unity_q, bc_zero_q};
        else if (int'(bus.dmp_addr[7:4]) < BANKS)    dmp_nxt = bank_q[bus.dmp_addr[RW+3:4]][bus.dmp_addr[3:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          dmp_q <= 8'd0;
        else if (bus.cen) dmp_q <= dmp_nxt;
    end

    assign bus.dmp_din = dmp_q;
`else
    logic unused_dmp;
    assign unused_dmp  = ^{bus.dmp_addr, rstk_cnt};
    assign bus.dmp_din = 8'd0;
`endif
endmodule

// File: tb/tb_jt900h_rfile_banked.sv
// Directed bench for jt900h_rfile_banked (BANKS=4, RSTK_DEPTH=2, SP_RST=0x100).
module tb_jt900h_rfile_banked;
    localparam int BANKS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    jt900h_rfile_banked_if #(.BANKS(BANKS)) bus();

    jt900h_rfile_banked #(
        .BANKS(BANKS), .RSTK_DEPTH(2), .SP_RST(32'h0000_0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cen = 1'b1;   bus.rfp_we = 1'b0;   bus.rfp_din = '0;
        bus.rfp_inc = 1'b0; bus.rfp_dec = 1'b0; bus.rfp_push = 1'b0; bus.rfp_pop = 1'b0;
        bus.rsel_a = 8'h00; bus.rsel_b = 8'h00; bus.step_inc = 1'b0; bus.step_dec = 1'b0;
        bus.step_sz = 2'd0; bus.we = 3'd0;     bus.wdata = 32'd0;   bus.dec_bc = 1'b0;
        bus.sp_inc = 16'd0; bus.sp_dec = 16'd0; bus.dmp_addr = 8'h00;
    endtask

    task automatic wr(input logic [7:0] code, input logic [2:0] we, input logic [31:0] d);
        bus.rsel_b = code; bus.we = we; bus.wdata = d;
        tick();
        bus.we = 3'd0;
    endtask

    task automatic look_a(input string tag, input logic [7:0] code, input logic [31:0] exp);
        bus.rsel_a = code;
        #1;
        chk(tag, bus.rd_a, exp);
    endtask

    task automatic look_b(input string tag, input logic [7:0] code, input logic [31:0] exp);
        bus.rsel_b = code;
        #1;
        chk(tag, bus.rd_b, exp);
    endtask

    task automatic dump(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        bus.dmp_addr = addr;
        tick();
`ifdef JT900H_RFILE_DUMP_EN
        chk(tag, 32'(bus.dmp_din), 32'(exp));
`else
        chk(tag, 32'(bus.dmp_din), 32'(exp & 8'h00));
`endif
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_rfp",    32'(bus.rfp), 32'h0);
        chk("rst_xsp",    bus.xsp, 32'h0000_0100);
        chk("rst_full",   32'(bus.rstk_full), 32'h0);
        chk("rst_err",    32'(bus.rstk_err), 32'h0);
        chk("rst_bcz",    32'(bus.bc_zero), 32'h1);
        chk("rst_bcu",    32'(bus.bc_unity), 32'h0);
        chk("rst_acc",    bus.acc, 32'h0);
        chk("rst_dmp",    32'(bus.dmp_din), 32'h0);

        // full dump sweep: only XSP byte 1 (0xFD) and the BC-zero flag are nonzero
        for (int a = 0; a < 256; a++) begin
            logic [7:0] e;
            e = (a == 'hFD || a == 'hE1) ? 8'h01 : 8'h00;
            dump($sformatf("dump_%02h", a), 8'(a), e);
        end

        // current / previous bank addressing
        bus.rfp_we = 1'b1; bus.rfp_din = 2'd1; tick(); bus.rfp_we = 1'b0;
        chk("rfp_load", 32'(bus.rfp), 32'h1);
        wr(8'hE0, 3'b100, 32'h1122_3344);
        look_a("bank1_xwa",  8'h10, 32'h1122_3344);
        look_b("prev_bank0", 8'hD0, 32'h0);
        chk("acc", bus.acc, 32'h1122_3344);
        wr(8'hE1, 3'b010, 32'h0000_BEEF);
        look_a("word_wr",   8'h10, 32'h1122_BEEF);
        wr(8'h12, 3'b011, 32'h0000_CAFE);
        look_a("word_prio", 8'h10, 32'hCAFE_BEEF);
        wr(8'h13, 3'b001, 32'h0000_005A);
        look_a("byte_wr",   8'h10, 32'h5AFE_BEEF);
        wr(8'h00, 3'b100, 32'hCAFE_0000);
        look_b("prev_bank0b", 8'hD0, 32'hCAFE_0000);
        wr(8'h50, 3'b100, 32'hFFFF_FFFF);
        look_a("bad_code",  8'h50, 32'h0);
        look_a("bad_nowr",  8'h10, 32'h5AFE_BEEF);
        bus.cen = 1'b0; wr(8'h10, 3'b100, 32'h0); bus.cen = 1'b1;
        look_a("cen_hold",  8'h10, 32'h5AFE_BEEF);

        // step and step/write merging
        wr(8'hF0, 3'b100, 32'h0000_0FFE);
        bus.rsel_a = 8'hF0; bus.step_inc = 1'b1; bus.step_sz = 2'd2; tick(); bus.step_inc = 1'b0;
        look_a("step_inc4", 8'hF0, 32'h0000_1002);
        wr(8'hF0, 3'b100, 32'h0000_0FFE);
        bus.rsel_a = 8'hF0; bus.step_inc = 1'b1; bus.step_sz = 2'd2;
        wr(8'hF0, 3'b001, 32'h0000_00AA);
        bus.step_inc = 1'b0;
        look_a("step_merge", 8'hF0, 32'h0000_10AA);
        bus.rsel_a = 8'hF0; bus.rsel_b = 8'hF0; bus.step_dec = 1'b1; bus.step_sz = 2'd1;
        #1 chk("rdb_predec", bus.rd_b, 32'h0000_10A8);
        tick(); bus.step_dec = 1'b0;
        look_a("step_dec2", 8'hF0, 32'h0000_10A8);
        bus.step_inc = 1'b1; bus.step_dec = 1'b1; tick(); bus.step_inc = 1'b0; bus.step_dec = 1'b0;
        look_a("step_both", 8'hF0, 32'h0000_10A8);
        wr(8'hF4, 3'b100, 32'hFFFF_FFFF);
        bus.rsel_a = 8'hF4; bus.step_inc = 1'b1; bus.step_sz = 2'd3; tick(); bus.step_inc = 1'b0;
        look_a("step_wrap", 8'hF4, 32'h0);

        // BC flags (current bank 1)
        wr(8'hE4, 3'b010, 32'h0000_0001);
        chk("bc1_unity", 32'(bus.bc_unity), 32'h1);
        chk("bc1_zero",  32'(bus.bc_zero),  32'h0);
        bus.dec_bc = 1'b1; tick(); bus.dec_bc = 1'b0;
        chk("bc0_zero",  32'(bus.bc_zero),  32'h1);
        chk("bc0_unity", 32'(bus.bc_unity), 32'h0);
        bus.dec_bc = 1'b1; tick(); bus.dec_bc = 1'b0;
        chk("bcw_zero",  32'(bus.bc_zero),  32'h0);
        look_a("bc_wrap", 8'hE4, 32'h0000_FFFF);
        dump("dmp_flags", 8'hE1, 8'h00);
        dump("dmp_bc_lo", 8'h14, 8'hFF);

        // RFP stack, depth 2
        bus.rfp_push = 1'b1; bus.rfp_din = 2'd1; tick();
        bus.rfp_din = 2'd2; tick();
        chk("push2_rfp",  32'(bus.rfp), 32'h2);
        chk("push2_full", 32'(bus.rstk_full), 32'h1);
        chk("push2_err",  32'(bus.rstk_err), 32'h0);
        bus.rfp_din = 2'd3; tick(); bus.rfp_push = 1'b0;
        chk("push3_rfp",  32'(bus.rfp), 32'h3);
        chk("push3_full", 32'(bus.rstk_full), 32'h1);
        chk("push3_err",  32'(bus.rstk_err), 32'h1);
        bus.rfp_pop = 1'b1; tick();
        chk("pop1_rfp",  32'(bus.rfp), 32'h2);
        chk("pop1_full", 32'(bus.rstk_full), 32'h0);
        tick(); chk("pop2_rfp", 32'(bus.rfp), 32'h1);
        tick(); chk("pop3_rfp", 32'(bus.rfp), 32'h1);
        bus.rfp_pop = 1'b0;
        chk("err_sticky", 32'(bus.rstk_err), 32'h1);
        dump("dmp_rfp0", 8'hE0, 8'h01);
        bus.rfp_push = 1'b1; bus.rfp_pop = 1'b1; bus.rfp_din = 2'd3; tick();
        bus.rfp_push = 1'b0; bus.rfp_pop = 1'b0;
        chk("pushpop_rfp", 32'(bus.rfp), 32'h3);
        dump("dmp_rfp1", 8'hE0, 8'h13);
        bus.rfp_pop = 1'b1; bus.rfp_we = 1'b1; bus.rfp_din = 2'd0; tick();
        bus.rfp_pop = 1'b0; bus.rfp_we = 1'b0;
        chk("pop_over_we", 32'(bus.rfp), 32'h1);
        bus.rfp_inc = 1'b1; tick(); chk("rfp_inc", 32'(bus.rfp), 32'h2);
        bus.rfp_dec = 1'b1; tick(); chk("rfp_incdec", 32'(bus.rfp), 32'h2);
        bus.rfp_inc = 1'b0; bus.rfp_dec = 1'b0;
        bus.rfp_we = 1'b1; bus.rfp_din = 2'd3; tick(); bus.rfp_we = 1'b0;
        bus.rfp_inc = 1'b1; tick(); bus.rfp_inc = 1'b0;
        chk("rfp_wrap_up", 32'(bus.rfp), 32'h0);
        wr(8'h30, 3'b100, 32'hDEAD_BEEF);
        look_b("prev_wrap", 8'hD0, 32'hDEAD_BEEF);
        bus.rfp_dec = 1'b1; tick(); bus.rfp_dec = 1'b0;
        chk("rfp_wrap_dn", 32'(bus.rfp), 32'h3);

        // XSP arithmetic
        chk("xsp_hold", bus.xsp, 32'h0000_0100);
        bus.sp_inc = 16'd4; bus.sp_dec = 16'd2; tick(); bus.sp_inc = 16'd0; bus.sp_dec = 16'd0;
        chk("xsp_incdec", bus.xsp, 32'h0000_0102);
        wr(8'hFC, 3'b100, 32'h0);
        bus.sp_dec = 16'd2; tick(); bus.sp_dec = 16'd0;
        chk("xsp_under", bus.xsp, 32'hFFFF_FFFE);
        bus.sp_inc = 16'd4; wr(8'hFC, 3'b100, 32'h1234_5678); bus.sp_inc = 16'd0;
        chk("xsp_wr_ovr", bus.xsp, 32'h1234_5678);
        look_a("xsp_rd", 8'hFC, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
